// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - binary32 field widths, special encodings and the unpacked operand type
package ieee754_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SIG_W   = FRAC_W + 1;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } operand_t;

  // Exponent 0 covers both zero and subnormals: both become a signed zero.
  function automatic operand_t unpack_op(input logic [31:0] v, input logic sgn);
    operand_t o;
    o.sign    = sgn;
    o.is_zero = (v[30:23] == '0);
    o.is_inf  = (v[30:23] == '1) && (v[22:0] == '0);
    o.is_nan  = (v[30:23] == '1) && (v[22:0] != '0);
    o.exp     = o.is_zero ? '0 : v[30:23];
    o.sig     = o.is_zero ? '0 : {1'b1, v[22:0]};
    return o;
  endfunction

endpackage

// File: rtl/ieee754_normalize.sv
// rtl/ieee754_normalize.sv - normalize the stage-2 sum and round to nearest, ties to even
module ieee754_normalize
  import ieee754_pkg::*;
(
  input  logic [27:0]        mant_i,
  input  logic [EXP_W-1:0]   exp_i,
  output logic [FRAC_W-1:0]  frac_o,
  output logic signed [9:0]  exp_o
);

  logic [4:0]        lz;
  logic [26:0]       w;
  logic signed [9:0] e;
  logic              round_up;
  logic [24:0]       sig_r;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (mant_i[i]) lz = 5'(26 - i);
    end

    // w = {24-bit significand, guard, round, sticky}
    if (mant_i[27]) begin
      w = {mant_i[27:2], |mant_i[1:0]};
      e = $signed({2'b00, exp_i}) + 10'sd1;
    end else begin
      w = mant_i[26:0] << lz;
      e = $signed({2'b00, exp_i}) - $signed({5'b00000, lz});
    end

    round_up = w[2] & ((|w[1:0]) | w[3]);
    sig_r    = {1'b0, w[26:3]} + 25'(round_up);

    if (sig_r[24]) begin
      frac_o = sig_r[23:1];
      exp_o  = e + 10'sd1;
    end else begin
      frac_o = sig_r[22:0];
      exp_o  = e;
    end
  end

endmodule

// File: rtl/ieee754_adder.sv
// rtl/ieee754_adder.sv - three-stage binary32 adder/subtractor, one operation per clock
module ieee754_adder
  import ieee754_pkg::*;
(
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        add_sub_bit,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] outputC
);

  operand_t op_a, op_b;
  operand_t big_d, small_d, big_q, small_q;

  logic [7:0]        diff;
  logic [4:0]        shamt;
  logic [49:0]       shifted;
  logic [26:0]       small_ext;
  logic [27:0]       mant_d, mant_q;
  logic              sign_d, sign_q;
  logic [EXP_W-1:0]  exp_d, exp_q;
  logic              spec_d, spec_q;
  logic [31:0]       spec_val_d, spec_val_q;

  logic [FRAC_W-1:0] norm_frac;
  logic signed [9:0] norm_exp;
  logic [31:0]       result_d, result_q;

  always_comb begin
    op_a = unpack_op(inputA, inputA[31]);
    op_b = unpack_op(inputB, inputB[31] ^ add_sub_bit);
    if ({op_a.exp, op_a.sig} >= {op_b.exp, op_b.sig}) begin
      big_d   = op_a;
      small_d = op_b;
    end else begin
      big_d   = op_b;
      small_d = op_a;
    end
  end

  // Shifts of 26 or more leave the small operand only as sticky.
  always_comb begin
    diff      = big_q.exp - small_q.exp;
    shamt     = (diff >= 8'd26) ? 5'd26 : diff[4:0];
    shifted   = {small_q.sig, 26'b0} >> shamt;
    small_ext = {shifted[49:24], |shifted[23:0]};
    if (big_q.sign == small_q.sign)
      mant_d = {1'b0, big_q.sig, 3'b000} + {1'b0, small_ext};
    else
      mant_d = {1'b0, big_q.sig, 3'b000} - {1'b0, small_ext};
    sign_d = big_q.sign;
    exp_d  = big_q.exp;

    spec_d     = 1'b1;
    spec_val_d = QNAN;
    if (big_q.is_nan || small_q.is_nan)
      spec_val_d = QNAN;
    else if (big_q.is_inf && small_q.is_inf)
      spec_val_d = (big_q.sign != small_q.sign) ? QNAN : (big_q.sign ? NEG_INF : POS_INF);
    else if (big_q.is_inf)
      spec_val_d = big_q.sign ? NEG_INF : POS_INF;
    else if (small_q.is_inf)
      spec_val_d = small_q.sign ? NEG_INF : POS_INF;
    else if (big_q.is_zero && small_q.is_zero)
      spec_val_d = (big_q.sign & small_q.sign) ? NEG_ZERO : POS_ZERO;
    else
      spec_d = 1'b0;
  end

  ieee754_normalize u_normalize (
    .mant_i (mant_q),
    .exp_i  (exp_q),
    .frac_o (norm_frac),
    .exp_o  (norm_exp)
  );

  always_comb begin
    result_d = {sign_q, norm_exp[7:0], norm_frac};
    if (spec_q)
      result_d = spec_val_q;
    else if (mant_q == '0)
      result_d = POS_ZERO;
    else if (int'(norm_exp) >= EXP_MAX)
      result_d = sign_q ? NEG_INF : POS_INF;
    else if (int'(norm_exp) <= 0)
      result_d = {sign_q, 31'b0};
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      big_q      <= '0;
      small_q    <= '0;
      mant_q     <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      big_q      <= big_d;
      small_q    <= small_d;
      mant_q     <= mant_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

  assign outputC = result_q;

endmodule

// File: tb/tb_ieee754_adder.sv
// tb/tb_ieee754_adder.sv - directed vectors streamed back-to-back plus mid-stream reset
module tb_ieee754_adder;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
  } vec_t;

  logic        clock_in = 1'b0;
  logic        reset_n_in;
  logic        add_sub_bit;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [31:0] outputC;

  int   tests_run    = 0;
  int   tests_failed = 0;
  vec_t vecs[$];

  always #5 clock_in = ~clock_in;

  ieee754_adder dut (
    .clock_in    (clock_in),
    .reset_n_in  (reset_n_in),
    .add_sub_bit (add_sub_bit),
    .inputA      (inputA),
    .inputB      (inputB),
    .outputC     (outputC)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [31:0] r);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.r = r;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    inputA      = v.a;
    inputB      = v.b;
    add_sub_bit = v.op;
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    add(32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000);
    add(32'h3F000000, 32'h3FC00000, 1'b0, 32'h40000000);
    add(32'h3FC00000, 32'hBF000000, 1'b0, 32'h3F800000);
    add(32'h3F000000, 32'hBFC00000, 1'b0, 32'hBF800000);
    add(32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000);
    add(32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000);
    add(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    add(32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
    add(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    add(32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000);
    add(32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000);
    add(32'h40E00000, 32'h40C00000, 1'b1, 32'h3F800000);
    add(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    add(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    add(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
    add(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
    add(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    add(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000);
    add(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    add(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000);
    add(32'h00000001, 32'h00000000, 1'b0, 32'h00000000);
    add(32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    add(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    add(32'hBF800000, 32'h80000000, 1'b0, 32'hBF800000);
    add(32'h80C00000, 32'h00800000, 1'b0, 32'h80000000);
    add(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000);

    reset_n_in  = 1'b0;
    inputA      = 32'h3F800000;
    inputB      = 32'h3F800000;
    add_sub_bit = 1'b0;
    step();
    step();
    check("reset", outputC, 32'h00000000);
    step();
    check("reset_hold", outputC, 32'h00000000);

    reset_n_in = 1'b1;
    for (int t = 0; t < vecs.size() + 2; t++) begin
      if (t < vecs.size()) drive(vecs[t]);
      step();
      if (t >= 2) check($sformatf("vec%0d", t - 2), outputC, vecs[t-2].r);
    end

    for (int t = 0; t < 4; t++) begin
      drive(vecs[t]);
      step();
      if (t >= 2) check($sformatf("pre_rst%0d", t - 2), outputC, vecs[t-2].r);
    end
    reset_n_in = 1'b0;
    drive(vecs[4]);
    step();
    check("rst_mid", outputC, 32'h00000000);
    reset_n_in = 1'b1;
    for (int t = 0; t < 3; t++) begin
      drive(vecs[7 + t]);
      step();
      if (t < 2) check($sformatf("rst_flush%0d", t), outputC, 32'h00000000);
      else       check("rst_first", outputC, vecs[7].r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
